uart_receiver: RTL and testbench

Receives 8N1 asynchronous serial frames on `serial_in` and presents bytes to the CPU's memory-mapped UART control logic through a ready/valid interface. It sits between the board serial pin (the host-side stream that drives the BIOS console) and the CPU's UART status/data registers. It oversamples with a clock-derived bit timer, rejects glitched start bits, flags framing errors, and buffers received bytes in a small FIFO so the BIOS polling loop can fall behind by several characters without losing data.

---
 rtl/uart_receiver_pkg.sv | 28 ++
 rtl/uart_receiver_fifo.sv | 66 ++++++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver FSM state encoding and bit-timing helpers.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Core clocks per serial bit, rounded down.
    function automatic int symbol_ticks(
        input int clock_freq,
        input int baud_rate
    );
        return clock_freq / baud_rate;
    endfunction

    // Tick inside a bit at which the line is sampled (bit midpoint).
    function automatic int sample_tick(
        input int clock_freq,
        input int baud_rate
    );
        return symbol_ticks(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst (sync, active high); push/push_data write side;
// pop/data_out/data_valid read side (head shown combinationally);
// full/empty status. A push while full is ignored by this block.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign data_valid = !empty;
    assign data_out   = mem[rd_ptr];

    // A full FIFO refuses the push even when a pop frees a slot in
    // the same cycle; the caller reports that as an overflow.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with glitch-rejecting start detection, framing
// error and overflow pulses, and a FWFT byte FIFO toward the CPU.
// Ports: clk, rst (sync, active high), serial_in (async line),
// data_out/data_out_valid/data_out_ready (ready/valid byte stream),
// frame_error and overflow (one-cycle event pulses).
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       frame_error,
    output logic       overflow
);

    localparam int SYMBOL_TICKS = symbol_ticks(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TICK  = sample_tick(CLOCK_FREQ, BAUD_RATE);
    localparam int TCLOG = $clog2(SYMBOL_TICKS);
    localparam int TW    = (TCLOG > 0) ? TCLOG : 1;

    localparam logic [TW-1:0] TICK_SAMPLE = TW'(SAMPLE_TICK);
    localparam logic [TW-1:0] TICK_LAST   = TW'(SYMBOL_TICKS - 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic          sync_meta;
    logic          rx;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          push;
    logic          frame_error_next;
    logic          fifo_full;
    logic          fifo_empty;

    // Two-flop synchronizer; resets to the idle (high) line level so
    // reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rx        <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            rx        <= sync_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RX_IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frame_error <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_next;
            tick        <= tick_next;
            bit_idx     <= bit_idx_next;
            shift       <= shift_next;
            frame_error <= frame_error_next;
            overflow    <= push && fifo_full;
        end
    end

    always_comb begin
        state_next       = state;
        tick_next        = tick + TW'(1);
        bit_idx_next     = bit_idx;
        shift_next       = shift;
        push             = 1'b0;
        frame_error_next = 1'b0;
        unique case (state)
            RX_IDLE: begin
                tick_next = '0;
                if (!rx) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                // High at the start-bit midpoint means the low level
                // was a glitch, not a real start bit.
                if (tick == TICK_SAMPLE && rx) begin
                    state_next = RX_IDLE;
                    tick_next  = '0;
                end else if (tick == TICK_LAST) begin
                    state_next   = RX_DATA;
                    tick_next    = '0;
                    bit_idx_next = '0;
                end
            end
            RX_DATA: begin
                if (tick == TICK_SAMPLE) begin
                    shift_next = {rx, shift[7:1]};
                end
                if (tick == TICK_LAST) begin
                    tick_next    = '0;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Leave at the stop-bit midpoint so the next start
                // edge is caught with half a bit of margin.
                if (tick == TICK_SAMPLE) begin
                    if (rx) begin
                        push = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                    state_next = RX_IDLE;
                    tick_next  = '0;
                end
            end
        endcase
    end

    fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shift),
        .pop       (data_out_ready),
        .data_out  (data_out),
        .data_valid(data_out_valid),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 5 clocks per bit.
// Frame vectors, hand-built corner cases and a random frame stream.
module tb_uart_receiver;

    localparam int ST = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_error;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] rxq [$];

    always #5 clk = ~clk;

    uart_receiver #(
        .CLOCK_FREQ(50_000_000),
        .BAUD_RATE (10_000_000),
        .FIFO_DEPTH(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .frame_error   (frame_error),
        .overflow      (overflow)
    );

    // Observe handshakes and event pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) rxq.push_back(data_out);
            if (frame_error) ferr_cnt++;
            if (overflow) ovf_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (ST) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        serial_in = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int first_n;
        int valid_cycles;
        logic [7:0] first_data;
        int base;
        int fe0;
        int ov0;
        logic [7:0] expq [$];
        int exp_fe;

        vecs[0] = '{8'h61, 1'b1, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1, 0};
        vecs[2] = '{8'hff, 1'b1, 1, 0};
        vecs[3] = '{8'h55, 1'b0, 0, 1};
        vecs[4] = '{8'ha5, 1'b1, 1, 0};
        vecs[5] = '{8'h80, 1'b0, 0, 1};
        vecs[6] = '{8'h00, 1'b0, 0, 1};
        vecs[7] = '{8'h01, 1'b1, 1, 0};

        rst = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b0;
        idle(3);
        check("reset valid", int'(data_out_valid), 0);
        check("reset frame_error", int'(frame_error), 0);
        check("reset overflow", int'(overflow), 0);
        rst = 1'b0;
        idle(4);

        // Latency: counted from the first clock edge that samples the
        // falling start edge; valid must appear 50 edges after it.
        data_out_ready = 1'b1;
        first_n = -1;
        valid_cycles = 0;
        first_data = 8'h00;
        fe0 = ferr_cnt;
        ov0 = ovf_cnt;
        fork
            send_frame(8'h61, 1'b1);
            begin
                for (int n = 0; n <= 60; n++) begin
                    if (data_out_valid) begin
                        if (first_n < 0) begin
                            first_n = n;
                            first_data = data_out;
                        end
                        valid_cycles++;
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        check("latency edge", first_n, 51);
        check("latency valid cycles", valid_cycles, 1);
        check("latency data", int'(first_data), 'h61);
        check("latency frame_error", ferr_cnt - fe0, 0);
        check("latency overflow", ovf_cnt - ov0, 0);
        idle(4);

        foreach (vecs[i]) begin
            base = rxq.size();
            fe0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_ok);
            idle(8);
            check("vec push", rxq.size() - base, vecs[i].exp_push);
            if (rxq.size() > base) check("vec data", int'(rxq[$]), int'(vecs[i].data));
            check("vec frame_error", ferr_cnt - fe0, vecs[i].exp_ferr);
            check("vec empty after", int'(data_out_valid), 0);
        end

        // One-cycle start glitch, then a real frame.
        base = rxq.size();
        fe0 = ferr_cnt;
        serial_in = 1'b0;
        idle(1);
        serial_in = 1'b1;
        idle(12);
        check("glitch push", rxq.size() - base, 0);
        check("glitch frame_error", ferr_cnt - fe0, 0);
        send_frame(8'h3e, 1'b1);
        idle(8);
        check("post glitch count", rxq.size() - base, 1);
        if (rxq.size() > base) check("post glitch data", int'(rxq[$]), 'h3e);

        // Fill past capacity with the consumer stalled.
        data_out_ready = 1'b0;
        base = rxq.size();
        ov0 = ovf_cnt;
        for (int i = 0; i < 9; i++) begin
            send_frame(8'h30 + 8'(i), 1'b1);
            idle(4);
        end
        idle(4);
        check("overflow pulses", ovf_cnt - ov0, 1);
        check("full valid", int'(data_out_valid), 1);
        check("full head", int'(data_out), 'h30);
        check("stalled pops", rxq.size() - base, 0);

        // Pop and push land on the same edge while full.
        ov0 = ovf_cnt;
        fork
            send_frame(8'h40, 1'b1);
            begin
                repeat (50) @(posedge clk);
                #1;
                data_out_ready = 1'b1;
                @(posedge clk);
                #1;
                data_out_ready = 1'b0;
            end
        join
        idle(6);
        check("simul overflow", ovf_cnt - ov0, 1);
        check("simul pop count", rxq.size() - base, 1);
        if (rxq.size() > base) check("simul pop data", int'(rxq[$]), 'h30);

        base = rxq.size();
        data_out_ready = 1'b1;
        idle(12);
        check("drain count", rxq.size() - base, 7);
        for (int i = 0; i < 7; i++) begin
            if (base + i < rxq.size())
                check("drain data", int'(rxq[base+i]), 'h31 + i);
        end
        check("drain valid low", int'(data_out_valid), 0);

        // Reset mid-frame also flushes a buffered byte.
        data_out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(8);
        check("buffered before rst", int'(data_out_valid), 1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(logic'((8'hca >> i) & 8'h01));
        serial_in = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(3);
        for (int i = 5; i < 8; i++) drive_bit(logic'((8'hca >> i) & 8'h01));
        drive_bit(1'b1);
        idle(2);
        rst = 1'b0;
        idle(1);
        check("rst flush valid", int'(data_out_valid), 0);
        base = rxq.size();
        fe0 = ferr_cnt;
        data_out_ready = 1'b1;
        idle(4);
        send_frame(8'hfe, 1'b1);
        idle(8);
        check("after rst count", rxq.size() - base, 1);
        if (rxq.size() > base) check("after rst data", int'(rxq[$]), 'hfe);
        check("after rst frame_error", ferr_cnt - fe0, 0);

        // Random frames: good stop bits deliver bytes in order, bad
        // ones only count as framing errors.
        base = rxq.size();
        fe0 = ferr_cnt;
        exp_fe = 0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] b;
            logic good;
            b = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            if (good) expq.push_back(b);
            else exp_fe++;
            send_frame(b, good);
            idle($urandom_range(4, 9));
        end
        idle(10);
        check("random count", rxq.size() - base, expq.size());
        check("random frame_error", ferr_cnt - fe0, exp_fe);
        foreach (expq[i]) begin
            if (base + i < rxq.size())
                check("random data", int'(rxq[base+i]), int'(expq[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
